// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the RV32I pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FWD_W      = 2;

    // EX-stage operand source selects
    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    // Sequencing FSM states
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hazState_t;

    // Pick the youngest in-flight producer of a source register; x0 is never forwarded.
    function automatic logic [FWD_W-1:0] fwdSel(
        input logic                  wrEnM,
        input logic [REG_ADDR_W-1:0] rdM,
        input logic                  wrEnW,
        input logic [REG_ADDR_W-1:0] rdW,
        input logic [REG_ADDR_W-1:0] rs
    );
        if (wrEnM && (rdM != '0) && (rdM == rs)) begin
            return FWD_MEM;
        end else if (wrEnW && (rdW != '0) && (rdW == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard debug counters.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, holding at all-ones instead of wrapping
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush, forwarding and memory-wait sequencing for the 5-stage pipeline.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [REG_ADDR_W-1:0] i_rs1_addrD,
    input  logic [REG_ADDR_W-1:0] i_rs2_addrD,
    input  logic [REG_ADDR_W-1:0] i_rs1_addrE,
    input  logic [REG_ADDR_W-1:0] i_rs2_addrE,
    input  logic [REG_ADDR_W-1:0] i_rd_addrE,
    input  logic                  i_result_srcE,
    input  logic [REG_ADDR_W-1:0] i_rd_addrM,
    input  logic                  i_reg_wr_enM,
    input  logic [REG_ADDR_W-1:0] i_rd_addrW,
    input  logic                  i_reg_wr_enW,
    input  logic                  i_pc_srcE,
    input  logic                  i_dmem_reqM,
    input  logic                  i_dmem_readyM,
    output logic [FWD_W-1:0]      o_fwd_aE,
    output logic [FWD_W-1:0]      o_fwd_bE,
    output logic                  o_stallF,
    output logic                  o_stallD,
    output logic                  o_stallE,
    output logic                  o_stallM,
    output logic                  o_flushD,
    output logic                  o_flushE,
    output logic                  o_flushW,
    output logic                  o_mem_wait,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    hazState_t state;
    hazState_t stateNext;
    logic      memStall;
    logic      lwStall;

    assign memStall = i_dmem_reqM && !i_dmem_readyM;
    assign lwStall  = i_result_srcE && (i_rd_addrE != '0) &&
                      ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));

    assign o_mem_wait = (state == ST_MEM_WAIT);

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= ST_RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next state, forwarding selects and prioritised stall/flush controls
    always_comb begin
        stateNext = state;
        o_fwd_aE  = fwdSel(i_reg_wr_enM, i_rd_addrM, i_reg_wr_enW, i_rd_addrW, i_rs1_addrE);
        o_fwd_bE  = fwdSel(i_reg_wr_enM, i_rd_addrM, i_reg_wr_enW, i_rd_addrW, i_rs2_addrE);
        o_stallF  = 1'b0;
        o_stallD  = 1'b0;
        o_stallE  = 1'b0;
        o_stallM  = 1'b0;
        o_flushD  = 1'b0;
        o_flushE  = 1'b0;
        o_flushW  = 1'b0;

        case (state)
            ST_RUN: begin
                if (memStall) begin
                    stateNext = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                // A dropped request while waiting is not legal; recover to RUN
                if (!i_dmem_reqM || i_dmem_readyM) begin
                    stateNext = ST_RUN;
                end
            end
            default: stateNext = ST_RUN;
        endcase

        // Controls stay quiet while reset is held
        if (i_rstn) begin
            if (memStall) begin
                // Freeze everything up to MEM; EX holds so a redirect there waits
                o_stallF = 1'b1;
                o_stallD = 1'b1;
                o_stallE = 1'b1;
                o_stallM = 1'b1;
                o_flushW = 1'b1;
            end else if (i_pc_srcE) begin
                // Redirect beats load-use: the stalled instruction is wrong-path
                o_flushD = 1'b1;
                o_flushE = 1'b1;
            end else if (lwStall) begin
                o_stallF = 1'b1;
                o_stallD = 1'b1;
                o_flushE = 1'b1;
            end
        end
    end

    // Cycles with the front end held
    sat_counter #(
        .W(CNT_W)
    ) uStallCnt (
        .i_clk (i_clk),
        .i_rstn(i_rstn),
        .inc   (o_stallF),
        .count (o_stall_cnt)
    );

    // Redirect flushes issued
    sat_counter #(
        .W(CNT_W)
    ) uFlushCnt (
        .i_clk (i_clk),
        .i_rstn(i_rstn),
        .inc   (o_flushD),
        .count (o_flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rstn;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       resE, wrM, wrW, pcSrc, req, rdy;

    logic [1:0]  fa, fb;
    logic        sF, sD, sE, sM, fD, fE, fW, memWait;
    logic [31:0] stallCnt, flushCnt;

    logic [1:0]  faS, fbS;
    logic        sFS, sDS, sES, sMS, fDS, fES, fWS, memWaitS;
    logic [3:0]  stallCntS, flushCntS;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_rs1_addrD(rs1D), .i_rs2_addrD(rs2D),
        .i_rs1_addrE(rs1E), .i_rs2_addrE(rs2E), .i_rd_addrE(rdE),
        .i_result_srcE(resE),
        .i_rd_addrM(rdM), .i_reg_wr_enM(wrM),
        .i_rd_addrW(rdW), .i_reg_wr_enW(wrW),
        .i_pc_srcE(pcSrc), .i_dmem_reqM(req), .i_dmem_readyM(rdy),
        .o_fwd_aE(fa), .o_fwd_bE(fb),
        .o_stallF(sF), .o_stallD(sD), .o_stallE(sE), .o_stallM(sM),
        .o_flushD(fD), .o_flushE(fE), .o_flushW(fW),
        .o_mem_wait(memWait), .o_stall_cnt(stallCnt), .o_flush_cnt(flushCnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dutSmall (
        .i_clk(clk), .i_rstn(rstn),
        .i_rs1_addrD(rs1D), .i_rs2_addrD(rs2D),
        .i_rs1_addrE(rs1E), .i_rs2_addrE(rs2E), .i_rd_addrE(rdE),
        .i_result_srcE(resE),
        .i_rd_addrM(rdM), .i_reg_wr_enM(wrM),
        .i_rd_addrW(rdW), .i_reg_wr_enW(wrW),
        .i_pc_srcE(pcSrc), .i_dmem_reqM(req), .i_dmem_readyM(rdy),
        .o_fwd_aE(faS), .o_fwd_bE(fbS),
        .o_stallF(sFS), .o_stallD(sDS), .o_stallE(sES), .o_stallM(sMS),
        .o_flushD(fDS), .o_flushE(fES), .o_flushW(fWS),
        .o_mem_wait(memWaitS), .o_stall_cnt(stallCntS), .o_flush_cnt(flushCntS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
        logic       resE;
        logic [4:0] rdM;
        logic       wrM;
        logic [4:0] rdW;
        logic       wrW, pcSrc, req, rdy;
        logic [1:0] expA, expB;
        logic [6:0] expCtrl;   // {stallF,stallD,stallE,stallM,flushD,flushE,flushW}
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic logic [6:0] ctrl();
        return {sF, sD, sE, sM, fD, fE, fW};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; resE = 0;
        rdM = 0; wrM = 0; rdW = 0; wrW = 0; pcSrc = 0; req = 0; rdy = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
    endtask

    task automatic applyVec(input vec_t v);
        rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E; rdE = v.rdE;
        resE = v.resE; rdM = v.rdM; wrM = v.wrM; rdW = v.rdW; wrW = v.wrW;
        pcSrc = v.pcSrc; req = v.req; rdy = v.rdy;
    endtask

    initial begin
        //          name          rs1D rs2D rs1E rs2E rdE resE rdM wrM rdW wrW pc req rdy  A      B      ctrl
        vecs[0]  = '{"fwdA_mem",    0,   0,   5,   1,   0, 0,   5, 1,  0, 0,  0, 0, 0,  2'b10, 2'b00, 7'b0000000};
        vecs[1]  = '{"fwdA_x0",     0,   0,   0,   1,   0, 0,   0, 1,  0, 0,  0, 0, 0,  2'b00, 2'b00, 7'b0000000};
        vecs[2]  = '{"fwdB_memPri", 0,   0,   1,   7,   0, 0,   7, 1,  7, 1,  0, 0, 0,  2'b00, 2'b10, 7'b0000000};
        vecs[3]  = '{"fwdB_wb",     0,   0,   1,   7,   0, 0,   7, 0,  7, 1,  0, 0, 0,  2'b00, 2'b01, 7'b0000000};
        vecs[4]  = '{"fwdA_wb",     0,   0,   9,   2,   0, 0,   9, 0,  9, 1,  0, 0, 0,  2'b01, 2'b00, 7'b0000000};
        vecs[5]  = '{"fwd_wbX0",    0,   0,   0,   0,   0, 0,   4, 1,  0, 1,  0, 0, 0,  2'b00, 2'b00, 7'b0000000};
        vecs[6]  = '{"lw_rs1",      3,   0,   0,   0,   3, 1,   0, 0,  0, 0,  0, 0, 0,  2'b00, 2'b00, 7'b1100010};
        vecs[7]  = '{"lw_rs2",      1,   3,   0,   0,   3, 1,   0, 0,  0, 0,  0, 0, 0,  2'b00, 2'b00, 7'b1100010};
        vecs[8]  = '{"lw_x0",       0,   0,   0,   0,   0, 1,   0, 0,  0, 0,  0, 0, 0,  2'b00, 2'b00, 7'b0000000};
        vecs[9]  = '{"notLoad",     3,   0,   0,   0,   3, 0,   0, 0,  0, 0,  0, 0, 0,  2'b00, 2'b00, 7'b0000000};
        vecs[10] = '{"redirect",    0,   0,   0,   0,   0, 0,   0, 0,  0, 0,  1, 0, 0,  2'b00, 2'b00, 7'b0000110};
        vecs[11] = '{"redir_lw",    3,   0,   0,   0,   3, 1,   0, 0,  0, 0,  1, 0, 0,  2'b00, 2'b00, 7'b0000110};
        vecs[12] = '{"memStallPri", 3,   0,   0,   0,   3, 1,   0, 0,  0, 0,  1, 1, 0,  2'b00, 2'b00, 7'b1111001};
        vecs[13] = '{"memReady",    0,   0,   0,   0,   0, 0,   0, 0,  0, 0,  0, 1, 1,  2'b00, 2'b00, 7'b0000000};

        idle();
        rstn = 1'b0;
        // Reset state, with a forwarding match and a pending stall source present
        rdM = 5; wrM = 1; rs1E = 5; req = 1; pcSrc = 1;
        #12;
        chk("rst_memWait", 32'(memWait), 0);
        chk("rst_stallCnt", stallCnt, 0);
        chk("rst_flushCnt", flushCnt, 0);
        chk("rst_ctrl", 32'(ctrl()), 0);
        chk("rst_fwdA", 32'(fa), 32'(2'b10));
        idle();
        @(negedge clk);
        rstn = 1'b1;

        // Combinational vector table
        for (int i = 0; i < NV; i++) begin
            cyc();
            applyVec(vecs[i]);
            #3;
            chk({vecs[i].name, "_fwdA"}, 32'(fa), 32'(vecs[i].expA));
            chk({vecs[i].name, "_fwdB"}, 32'(fb), 32'(vecs[i].expB));
            chk({vecs[i].name, "_ctrl"}, 32'(ctrl()), 32'(vecs[i].expCtrl));
        end
        idle();

        // Load-use: one stall cycle then the bubble clears it
        doReset();
        cyc();
        resE = 1; rdE = 3; rs1D = 3;
        #3;
        chk("lu_ctrl", 32'(ctrl()), 32'(7'b1100010));
        cyc();
        idle();
        #3;
        chk("lu_after", 32'(ctrl()), 0);
        chk("lu_stallCnt", stallCnt, 1);

        // Redirect alone, then redirect with a load-use
        cyc();
        pcSrc = 1;
        #3;
        chk("rd_ctrl", 32'(ctrl()), 32'(7'b0000110));
        cyc();
        idle();
        #3;
        chk("rd_flushCnt", flushCnt, 1);
        cyc();
        pcSrc = 1; resE = 1; rdE = 3; rs2D = 3;
        #3;
        chk("rdlu_stallF", 32'(sF), 0);
        chk("rdlu_flushD", 32'(fD), 1);
        cyc();
        idle();
        #3;
        chk("rdlu_flushCnt", flushCnt, 2);
        chk("rdlu_stallCnt", stallCnt, 1);

        // Three wait cycles, then ready, with a redirect pending throughout
        doReset();
        cyc();
        req = 1; rdy = 0; pcSrc = 1;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk($sformatf("mw%0d_ctrl", i), 32'(ctrl()), 32'(7'b1111001));
            chk($sformatf("mw%0d_wait", i), 32'(memWait), (i == 0) ? 0 : 1);
            chk($sformatf("mw%0d_stallCnt", i), stallCnt, 32'(i));
            cyc();
        end
        rdy = 1;
        #3;
        chk("mwRel_ctrl", 32'(ctrl()), 32'(7'b0000110));
        chk("mwRel_wait", 32'(memWait), 1);
        cyc();
        idle();
        #3;
        chk("mwDone_wait", 32'(memWait), 0);
        chk("mwDone_stallCnt", stallCnt, 3);
        chk("mwDone_flushCnt", flushCnt, 1);

        // Request dropped while waiting: recover to RUN
        cyc();
        req = 1;
        cyc();
        #3;
        chk("drop_inWait", 32'(memWait), 1);
        req = 0;
        #1;
        chk("drop_ctrl", 32'(ctrl()), 0);
        cyc();
        #3;
        chk("drop_back", 32'(memWait), 0);

        // Reset pulse in the middle of a wait
        req = 1;
        cyc(); cyc(); cyc();
        #3;
        chk("rw_preWait", 32'(memWait), 1);
        rstn = 1'b0;
        #1;
        chk("rw_wait", 32'(memWait), 0);
        chk("rw_stallCnt", stallCnt, 0);
        chk("rw_stallF", 32'(sF), 0);
        rstn = 1'b1;
        idle();

        // Saturation: 20 stall cycles and 17 flushes against a 4-bit copy
        doReset();
        cyc();
        req = 1;
        repeat (20) cyc();
        req = 0;
        cyc();
        pcSrc = 1;
        repeat (17) cyc();
        idle();
        #3;
        chk("sat_stallBig", stallCnt, 20);
        chk("sat_stallSmall", 32'(stallCntS), 15);
        chk("sat_flushBig", flushCnt, 17);
        chk("sat_flushSmall", 32'(flushCntS), 15);
        req = 1;
        repeat (3) cyc();
        #3;
        chk("sat_hold", 32'(stallCntS), 15);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
